// File: rtl/serial_demux_deserializer.sv
// ---------------------------------------------------------------------------
// serial_demux_deserializer
//
// Routes a serial bit stream into the bit positions of a WIDTH-bit word, one
// bit per accepted beat. A bit counter steers each bit to its slot. A
// completed word is handed off through a one-deep output register with a
// valid/ready handshake.
//
// Optional feature (macro SERIAL_DEMUX_PARITY_EN):
//   defined   - one extra even-parity beat follows the WIDTH data beats. It is
//               not stored in word_out. word_err flags odd total ones.
//   undefined - words are WIDTH beats long and word_err is constant 0.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  0: first bit lands in bit 0; 1: first bit lands in WIDTH-1
//   CNTW       bit-counter width (derived, do not override)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bit_in      serial data bit
//   bit_valid   bit_in is valid this cycle
//   bit_ready   block accepts bit_in this cycle
//   flush       discard the partially assembled word
//   word_out    assembled word, stable while word_valid=1
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer takes word_out this cycle
//   word_err    parity error for word_out, qualified by word_valid
//   bit_idx     number of beats accepted in the current word
// ---------------------------------------------------------------------------
module serial_demux_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNTW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_err,
  output logic [CNTW-1:0]  bit_idx
);

`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  localparam logic [CNTW-1:0] LAST_C = CNTW'(LAST);
  localparam logic [CNTW-1:0] TOP_C  = CNTW'(WIDTH - 1);

  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] data_buf;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] word_q;
  logic             valid_q;
  logic [CNTW-1:0]  pos;
  logic             is_last;
  logic             accept;
  logic             complete;

  assign is_last = (cnt == LAST_C);

  // Only the completing beat waits on the consumer; earlier beats go into
  // data_buf, which is independent of the held word.
  assign bit_ready = rst_n && !flush && !(is_last && valid_q && !word_ready);
  assign accept    = bit_valid && bit_ready;
  assign complete  = accept && is_last;

  assign pos = MSB_FIRST ? (TOP_C - cnt) : cnt;

  // During the parity beat (cnt == WIDTH) pos lands outside 0..WIDTH-1 in
  // both orders, so no slot matches and merged is just data_buf.
  always_comb begin
    // NOTE: default assignment first so no path leaves merged unassigned,
    // which would otherwise infer a latch.
    merged = data_buf;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos == CNTW'(i)) merged[i] = bit_in;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      data_buf <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (flush) begin
        cnt      <= '0;
        data_buf <= '0;
      end else if (complete) begin
        cnt      <= '0;
        data_buf <= '0;
      end else if (accept) begin
        cnt      <= cnt + 1'b1;
        data_buf <= merged;
      end

      // A completion in the same cycle as a consumption refills the register
      // directly, so there is no bubble between back-to-back words.
      if (complete) begin
        word_q  <= merged;
        valid_q <= 1'b1;
      end else if (valid_q && word_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SERIAL_DEMUX_PARITY_EN
  logic err_q;

  // Even parity: data ones plus the parity bit must total an even count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (complete) begin
      err_q <= (^data_buf) ^ bit_in;
    end
  end

  assign word_err = err_q;
`else
  assign word_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_idx    = cnt;

endmodule
